ir_cmd_queue: RTL and testbench

IR_CMD_QUEUE -- requirements
Module: ir_cmd_queue

---
 rtl/ir_cmd_queue_if.sv | 25 ++
 rtl/ir_cmd_queue.sv | 109 ++++++++++
 tb/tb_ir_cmd_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ir_cmd_queue_if.sv
// Bundle between the IR decoder / game FSM side and the command queue.
// The master drives the decoder code and the consumer ready; the slave is the queue.
interface ir_cmd_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  logic                      rdy;
  logic [2:0]                buttons;
  logic                      cmd_ready;
  logic                      cmd_valid;
  logic [1:0]                cmd_color;
  logic                      cmd_start;
  logic                      overflow;
  logic                      err_code;
  logic [$clog2(DEPTH):0]    level;

  modport master (
    output rdy, buttons, cmd_ready,
    input  cmd_valid, cmd_color, cmd_start, overflow, err_code, level
  );

  modport slave (
    input  rdy, buttons, cmd_ready,
    output cmd_valid, cmd_color, cmd_start, overflow, err_code, level
  );
endinterface

// File: rtl/ir_cmd_queue.sv
// IR command queue: edge-detects decoder codes, debounces them with a lockout
// window, maps them to game commands and buffers them in a small FIFO.
module ir_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LOCKOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  ir_cmd_queue_if.slave  bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned LkW  = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  // LOCKOUT of 0 or 1 loads 0, so the very next edge may capture again
  localparam logic [LkW-1:0]  LkLoad = (LOCKOUT > 0) ? LkW'(LOCKOUT - 1) : '0;
  localparam logic [LvlW-1:0] Full   = LvlW'(DEPTH);

  logic            rdy_q;
  logic [LkW-1:0]  lock_q, lock_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LvlW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [2:0]      mem_q [DEPTH];  // entry = {start, color[1:0]}

  logic       capture, accept, mapped, push, pop, full, do_push;
  logic [2:0] entry;
  logic [2:0] head;

  // Decode the button code into a queue entry; unmapped codes flag an error
  always_comb begin
    mapped = 1'b1;
    entry  = 3'b000;
    case (bus.buttons)
      3'b001:  entry = 3'b000;  // green
      3'b010:  entry = 3'b001;  // red
      3'b011:  entry = 3'b010;  // yellow
      3'b110:  entry = 3'b011;  // blue
      3'b100:  entry = 3'b100;  // START
      default: mapped = 1'b0;
    endcase
  end

  // Capture, lockout, FIFO pointer and flag next-state logic
  always_comb begin
    capture = bus.rdy & ~rdy_q;
    accept  = capture & (lock_q == '0);
    push    = accept & mapped;
    full    = (cnt_q == Full);
    pop     = (cnt_q != '0) & bus.cmd_ready;
    // a full FIFO still accepts when the head leaves on the same edge
    do_push = push & (~full | pop);

    lock_d = lock_q;
    if (accept) begin
      lock_d = LkLoad;
    end else if (lock_q != '0) begin
      lock_d = lock_q - LkW'(1);
    end

    err_d = accept & ~mapped;
    ovf_d = ovf_q | (push & full & ~pop);
    wr_d  = do_push ? wr_q + PtrW'(1) : wr_q;
    rd_d  = pop ? rd_q + PtrW'(1) : rd_q;

    cnt_d = cnt_q;
    case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + LvlW'(1);
      2'b01:   cnt_d = cnt_q - LvlW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q  <= 1'b0;
      lock_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rdy_q  <= bus.rdy;
      lock_q <= lock_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Storage array; contents are don't-care until covered by the occupancy count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= entry;
    end
  end

  assign head          = mem_q[rd_q];
  assign bus.cmd_valid = (cnt_q != '0);
  assign bus.cmd_color = (cnt_q != '0) ? head[1:0] : 2'b00;
  assign bus.cmd_start = (cnt_q != '0) ? head[2] : 1'b0;
  assign bus.overflow  = ovf_q;
  assign bus.err_code  = err_q;
  assign bus.level     = cnt_q;
endmodule

// File: tb/tb_ir_cmd_queue.sv
// Directed bench for ir_cmd_queue: three instances (default lockout, no lockout,
// short lockout) sharing clock and reset.
module tb_ir_cmd_queue;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ir_cmd_queue_if #(.DEPTH(4)) d_if ();
  ir_cmd_queue_if #(.DEPTH(4)) z_if ();
  ir_cmd_queue_if #(.DEPTH(4)) t_if ();

  ir_cmd_queue #(.DEPTH(4), .LOCKOUT(1000)) u_def (.clk(clk), .rst(rst), .bus(d_if));
  ir_cmd_queue #(.DEPTH(4), .LOCKOUT(0))    u_l0  (.clk(clk), .rst(rst), .bus(z_if));
  ir_cmd_queue #(.DEPTH(4), .LOCKOUT(10))   u_l10 (.clk(clk), .rst(rst), .bus(t_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_col [4];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    d_if.rdy = 1'b0; d_if.buttons = 3'b000; d_if.cmd_ready = 1'b0;
    z_if.rdy = 1'b0; z_if.buttons = 3'b000; z_if.cmd_ready = 1'b0;
    t_if.rdy = 1'b0; t_if.buttons = 3'b000; t_if.cmd_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(d_if.cmd_valid), 32'd0);
    chk("rst_level", 32'(d_if.level), 32'd0);
    chk("rst_ovf", 32'(d_if.overflow), 32'd0);
    chk("rst_err", 32'(d_if.err_code), 32'd0);
    chk("rst_color", 32'(d_if.cmd_color), 32'd0);
    chk("rst_start", 32'(d_if.cmd_start), 32'd0);
    rst = 1'b1;
    tick();

    // single capture, held rdy is one event
    d_if.buttons = 3'b011;
    d_if.rdy = 1'b1;
    tick();
    chk("cap_valid", 32'(d_if.cmd_valid), 32'd1);
    chk("cap_color", 32'(d_if.cmd_color), 32'd2);
    chk("cap_start", 32'(d_if.cmd_start), 32'd0);
    chk("cap_level", 32'(d_if.level), 32'd1);
    for (int i = 0; i < 50; i++) tick();
    chk("hold_level", 32'(d_if.level), 32'd1);
    chk("hold_color", 32'(d_if.cmd_color), 32'd2);
    d_if.rdy = 1'b0;

    // ordering and START
    z_if.buttons = 3'b001; z_if.rdy = 1'b1; tick();
    z_if.rdy = 1'b0; tick();
    z_if.buttons = 3'b100; z_if.rdy = 1'b1; tick();
    z_if.rdy = 1'b0; tick();
    z_if.buttons = 3'b110; z_if.rdy = 1'b1; tick();
    z_if.rdy = 1'b0;
    chk("ord_level", 32'(z_if.level), 32'd3);
    chk("ord_h0_color", 32'(z_if.cmd_color), 32'd0);
    chk("ord_h0_start", 32'(z_if.cmd_start), 32'd0);
    z_if.cmd_ready = 1'b1;
    tick();
    chk("ord_h1_start", 32'(z_if.cmd_start), 32'd1);
    chk("ord_h1_color", 32'(z_if.cmd_color), 32'd0);
    tick();
    chk("ord_h2_color", 32'(z_if.cmd_color), 32'd3);
    chk("ord_h2_start", 32'(z_if.cmd_start), 32'd0);
    tick();
    chk("ord_empty_valid", 32'(z_if.cmd_valid), 32'd0);
    chk("ord_empty_level", 32'(z_if.level), 32'd0);
    chk("ord_empty_color", 32'(z_if.cmd_color), 32'd0);
    z_if.cmd_ready = 1'b0;

    // overflow: five red events into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      z_if.buttons = 3'b010; z_if.rdy = 1'b1; tick();
      z_if.rdy = 1'b0;
      if (i == 3) begin
        chk("ovf_lvl4", 32'(z_if.level), 32'd4);
        chk("ovf_not_yet", 32'(z_if.overflow), 32'd0);
      end
      tick();
    end
    chk("ovf_level", 32'(z_if.level), 32'd4);
    chk("ovf_flag", 32'(z_if.overflow), 32'd1);
    z_if.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_valid", 32'(z_if.cmd_valid), 32'd1);
      chk("ovf_pop_color", 32'(z_if.cmd_color), 32'd1);
      tick();
    end
    chk("ovf_drained", 32'(z_if.cmd_valid), 32'd0);
    chk("ovf_sticky", 32'(z_if.overflow), 32'd1);
    z_if.cmd_ready = 1'b0;

    // async reset with level=3, rdy already high at release
    for (int i = 0; i < 3; i++) begin
      z_if.buttons = 3'b011; z_if.rdy = 1'b1; tick();
      z_if.rdy = 1'b0; tick();
    end
    chk("ar_pre_level", 32'(z_if.level), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_level", 32'(z_if.level), 32'd0);
    chk("ar_valid", 32'(z_if.cmd_valid), 32'd0);
    chk("ar_color", 32'(z_if.cmd_color), 32'd0);
    chk("ar_start", 32'(z_if.cmd_start), 32'd0);
    chk("ar_ovf", 32'(z_if.overflow), 32'd0);
    chk("ar_err", 32'(z_if.err_code), 32'd0);
    chk("ar_def_level", 32'(d_if.level), 32'd0);
    z_if.buttons = 3'b110;
    z_if.rdy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rel_event_level", 32'(z_if.level), 32'd1);
    chk("rel_event_color", 32'(z_if.cmd_color), 32'd3);
    z_if.rdy = 1'b0;
    z_if.cmd_ready = 1'b1;
    tick();
    z_if.cmd_ready = 1'b0;
    chk("rel_drained", 32'(z_if.level), 32'd0);

    // full plus simultaneous pop/push: blue enters as last entry
    for (int i = 0; i < 4; i++) begin
      z_if.buttons = 3'b010; z_if.rdy = 1'b1; tick();
      z_if.rdy = 1'b0; tick();
    end
    chk("fpp_pre_level", 32'(z_if.level), 32'd4);
    z_if.buttons = 3'b110;
    z_if.rdy = 1'b1;
    z_if.cmd_ready = 1'b1;
    tick();
    z_if.rdy = 1'b0;
    z_if.cmd_ready = 1'b0;
    chk("fpp_level", 32'(z_if.level), 32'd4);
    chk("fpp_ovf", 32'(z_if.overflow), 32'd0);
    exp_col[0] = 2'd1; exp_col[1] = 2'd1; exp_col[2] = 2'd1; exp_col[3] = 2'd3;
    z_if.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fpp_order", 32'(z_if.cmd_color), 32'(exp_col[i]));
      tick();
    end
    chk("fpp_empty", 32'(z_if.cmd_valid), 32'd0);
    z_if.cmd_ready = 1'b0;

    // lockout and invalid code (LOCKOUT=10)
    t_if.buttons = 3'b111; t_if.rdy = 1'b1; tick();   // E0
    t_if.rdy = 1'b0;
    chk("lk_err_pulse", 32'(t_if.err_code), 32'd1);
    chk("lk_err_level", 32'(t_if.level), 32'd0);
    tick();                                           // E1
    chk("lk_err_clear", 32'(t_if.err_code), 32'd0);
    for (int i = 0; i < 3; i++) tick();               // E2..E4
    t_if.buttons = 3'b001; t_if.rdy = 1'b1; tick();   // E5
    t_if.rdy = 1'b0;
    chk("lk_ignored_level", 32'(t_if.level), 32'd0);
    chk("lk_ignored_err", 32'(t_if.err_code), 32'd0);
    for (int i = 0; i < 6; i++) tick();               // E6..E11
    t_if.rdy = 1'b1; tick();                          // E12
    t_if.rdy = 1'b0;
    chk("lk_accept_level", 32'(t_if.level), 32'd1);
    chk("lk_accept_color", 32'(t_if.cmd_color), 32'd0);
    chk("lk_accept_start", 32'(t_if.cmd_start), 32'd0);
    chk("lk_ovf", 32'(t_if.overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
